uart_streaming_tx: RTL and testbench
====================================

# uart_streaming_tx

Frame transmitter for the FFT UART link: on a start pulse it reads N_SAMPLES 32-bit complex results from the output FIFO and serialises them as one frame. Each frame is SOF (4 bytes), a 16-bit status word (type and length), a payload of 4 bytes per sample, and EOF. Bytes go to the UART byte transmitter over a valid/ready handshake. This block is the counterpart of the receive-side frame parser and produces frames that parser accepts.

## Interface
- N_SAMPLES, 256, samples per frame; legal range 1..511 (4·N_SAMPLES ≤ 2047).
- FRAME_TYPE, 5'd1, value sent in the status type field.
- SOF_WORD, 32'hA55AC33C, SOF bytes, sent MSB byte first.
- EOF_BYTE, 8'h7E, terminating byte.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle request to send one frame; ignored while busy_o=1.
- fifo_empty_i  in  1  sample FIFO empty.
- fifo_data_i  in  32  sample {real[15:0], imag[15:0]}, valid the cycle after fifo_rd_o.
- fifo_rd_o  out  1  FIFO read strobe, one cycle per sample.
- tx_data_o  out  8  byte to UART transmitter.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  UART transmitter accepts a byte when tx_valid_o && tx_ready_i at a rising edge.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse after EOF is accepted.

## Operation
- States: IDLE, SOF0, SOF1, SOF2, SOF3, STAT0, STAT1, FETCH, WAIT_RD, REAL0, REAL1, IMAG0, IMAG1, EOF, DONE.
- IDLE: start_i=1 moves to SOF0. Otherwise stay in IDLE.
- Byte states (SOF0..STAT1, REAL0..IMAG1, EOF) behave as follows:
  - tx_valid_o=1 in every byte state.
  - The state advances only on tx_ready_i=1. Otherwise it holds, and tx_data_o is held stable.
- Byte values:
  - SOFk = SOF_WORD[31-8k -: 8].
  - STAT0 = status[15:8] and STAT1 = status[7:0], where status = {FRAME_TYPE, len[10:0]} and len = 4·N_SAMPLES (payload bytes).
  - REAL0/REAL1 = real MSB/LSB.
  - IMAG0/IMAG1 = imag MSB/LSB.
- STAT1 accepted → FETCH.
- FETCH:
  - If fifo_empty_i=0: fifo_rd_o=1 for exactly that cycle, then go to WAIT_RD.
  - If fifo_empty_i=1: stay in FETCH with fifo_rd_o=0. No timeout.
- WAIT_RD: latch fifo_data_i into the sample register, then go to REAL0.
- IMAG1 accepted:
  - Increment the sample counter (width clog2(N_SAMPLES+1)).
  - If the count reaches N_SAMPLES, go to EOF. Otherwise go to FETCH.
- EOF accepted → DONE.
- DONE: done_o=1 for one cycle, then go to IDLE. The sample counter clears on entry to SOF0.
- tx_valid_o, tx_data_o and fifo_rd_o are decoded from the state and sample registers only. There is no combinational path from tx_ready_i or start_i to any output.
- start_i asserted outside IDLE (including in DONE) is dropped and not queued.
- Reset mid-frame: the next cycle is IDLE with all outputs at their reset values. The partial frame is abandoned with no EOF, and the FIFO is not read further.

## Timing
- Reset values: tx_data_o=8'h00, tx_valid_o=0, fifo_rd_o=0, busy_o=0, done_o=0, state=IDLE, sample counter=0.
- tx_data_o=0 whenever tx_valid_o=0.
- Latencies below assume tx_ready_i held at 1 and the FIFO non-empty. Cycle 0 is the start_i cycle.
  - SOF0 is presented in cycle 1; STAT1 in cycle 6.
  - Sample k (0-based): FETCH at 7+6k, WAIT_RD at 8+6k, REAL0..IMAG1 at 9+6k..12+6k.
  - EOF at 7+6·N_SAMPLES; done_o at 8+6·N_SAMPLES.
- Each cycle of tx_ready_i=0 in a byte state, or of fifo_empty_i=1 in FETCH, adds exactly one cycle.
- Frame length on the wire: 7 + 4·N_SAMPLES bytes.

## Structure
- Shared package uart_frame_pkg, also used by the receiver:
  - state encoding;
  - SOF/EOF constants;
  - status field widths (type 5, len 11);
  - byte lane indices.
- No sub-module. The byte select is a case on the state inside this module.

## Test plan
- Default parameters, ready=1, FIFO preloaded with 256 words, first word 32'h1234ABCD:
  - bytes A5 5A C3 3C 0C 00 12 34 AB CD … 7E;
  - 1031 bytes in total;
  - done_o at cycle 1544.
- N_SAMPLES=1, tx_ready_i toggling 1/0 every cycle:
  - 11 bytes accepted in order, STAT=00 04;
  - tx_data_o stable through every ready=0 cycle;
  - frame takes 1+6+6+1 cycles plus one cycle per low-ready stall.
- fifo_empty_i held at 1 for 20 cycles in FETCH:
  - fifo_rd_o=0 and tx_valid_o=0 throughout;
  - transmission resumes two cycles after empty falls.
- start_i pulsed in SOF2 and again in DONE:
  - exactly one frame is sent;
  - busy_o=1 from cycle 1 until done_o.
- rst asserted during REAL1 of sample 3:
  - next cycle all outputs are 0 and state is IDLE;
  - a new start yields a full frame beginning A5 with the counter restarted;
  - no EOF is emitted for the aborted frame.
- FRAME_TYPE=5'd31, N_SAMPLES=511: status bytes FF FC; EOF follows the 2044th payload byte.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the FFT UART frame link, used by both transmitter and receiver.
package uart_frame_pkg;

    // Frame sequencer states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF0,
        ST_SOF1,
        ST_SOF2,
        ST_SOF3,
        ST_STAT0,
        ST_STAT1,
        ST_FETCH,
        ST_WAIT_RD,
        ST_REAL0,
        ST_REAL1,
        ST_IMAG0,
        ST_IMAG1,
        ST_EOF,
        ST_DONE
    } state_e;

    // Frame delimiters
    localparam logic [31:0] SOF_WORD_DEFAULT = 32'hA55AC33C;
    localparam logic [7:0]  EOF_BYTE_DEFAULT = 8'h7E;

    // Status word layout: {type, payload length in bytes}
    localparam int STAT_TYPE_W = 5;
    localparam int STAT_LEN_W  = 11;

    typedef struct packed {
        logic [STAT_TYPE_W-1:0] ftype;
        logic [STAT_LEN_W-1:0]  len;
    } status_t;

    // Byte lanes within a 32-bit word, lane 3 is the most significant byte
    localparam logic [1:0] LANE_3 = 2'd3;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_0 = 2'd0;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] lane);
        return w[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_streaming_tx.sv
// Serialises N_SAMPLES complex FIFO words into one SOF/status/payload/EOF frame
// and hands the bytes to the UART byte transmitter over valid/ready.
module uart_streaming_tx
    import uart_frame_pkg::*;
#(
    parameter int          N_SAMPLES  = 256,
    parameter logic [4:0]  FRAME_TYPE = 5'd1,
    parameter logic [31:0] SOF_WORD   = SOF_WORD_DEFAULT,
    parameter logic [7:0]  EOF_BYTE   = EOF_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        fifo_empty_i,
    input  logic [31:0] fifo_data_i,
    output logic        fifo_rd_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    localparam logic [STAT_LEN_W-1:0] LEN      = STAT_LEN_W'(4 * N_SAMPLES);
    localparam status_t               STATUS   = '{ftype: FRAME_TYPE, len: LEN};
    localparam logic [31:0]           STATUS_W = {16'h0000, STATUS};
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(N_SAMPLES - 1);

    state_e           state_q, state_d;
    logic [31:0]      sample_q, sample_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State, sample and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
        if (rst) begin
            state_q  <= ST_IDLE;
            // NOTE: the sample register is reset as well so tx_data_o never shows stale data from an aborted frame.
            sample_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: byte states advance on tx_ready_i, FETCH waits for data
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        state_d  = state_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SOF0;
                    cnt_d   = '0;
                end
            end
            ST_SOF0:  if (tx_ready_i) state_d = ST_SOF1;
            ST_SOF1:  if (tx_ready_i) state_d = ST_SOF2;
            ST_SOF2:  if (tx_ready_i) state_d = ST_SOF3;
            ST_SOF3:  if (tx_ready_i) state_d = ST_STAT0;
            ST_STAT0: if (tx_ready_i) state_d = ST_STAT1;
            ST_STAT1: if (tx_ready_i) state_d = ST_FETCH;
            ST_FETCH: if (!fifo_empty_i) state_d = ST_WAIT_RD;
            ST_WAIT_RD: begin
                sample_d = fifo_data_i;
                state_d  = ST_REAL0;
            end
            ST_REAL0: if (tx_ready_i) state_d = ST_REAL1;
            ST_REAL1: if (tx_ready_i) state_d = ST_IMAG0;
            ST_IMAG0: if (tx_ready_i) state_d = ST_IMAG1;
            ST_IMAG1: begin
                if (tx_ready_i) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LAST_IDX) ? ST_EOF : ST_FETCH;
                end
            end
            ST_EOF:   if (tx_ready_i) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and sample registers; tx_ready_i and start_i never reach an output
    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        fifo_rd_o  = 1'b0;
        busy_o     = (state_q != ST_IDLE);
        done_o     = (state_q == ST_DONE);
        unique case (state_q)
            ST_SOF0:  begin tx_valid_o = 1'b1; tx_data_o = byte_of(SOF_WORD, LANE_3); end
            ST_SOF1:  begin tx_valid_o = 1'b1; tx_data_o = byte_of(SOF_WORD, LANE_2); end
            ST_SOF2:  begin tx_valid_o = 1'b1; tx_data_o = byte_of(SOF_WORD, LANE_1); end
            ST_SOF3:  begin tx_valid_o = 1'b1; tx_data_o = byte_of(SOF_WORD, LANE_0); end
            ST_STAT0: begin tx_valid_o = 1'b1; tx_data_o = byte_of(STATUS_W, LANE_1); end
            ST_STAT1: begin tx_valid_o = 1'b1; tx_data_o = byte_of(STATUS_W, LANE_0); end
            ST_FETCH: fifo_rd_o = !fifo_empty_i;
            ST_REAL0: begin tx_valid_o = 1'b1; tx_data_o = byte_of(sample_q, LANE_3); end
            ST_REAL1: begin tx_valid_o = 1'b1; tx_data_o = byte_of(sample_q, LANE_2); end
            ST_IMAG0: begin tx_valid_o = 1'b1; tx_data_o = byte_of(sample_q, LANE_1); end
            ST_IMAG1: begin tx_valid_o = 1'b1; tx_data_o = byte_of(sample_q, LANE_0); end
            ST_EOF:   begin tx_valid_o = 1'b1; tx_data_o = EOF_BYTE; end
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_uart_streaming_tx.sv
// Directed bench for uart_streaming_tx: full default frame, ready toggling,
// FIFO starvation, dropped starts, mid-frame reset and a maximum-size frame.
module tb_uart_streaming_tx;
    import uart_frame_pkg::*;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    // Instance A: default parameters
    logic        a_start = 1'b0, a_empty = 1'b0, a_ready = 1'b1;
    logic [31:0] a_fdata = '0;
    logic        a_rd, a_valid, a_busy, a_done;
    logic [7:0]  a_data;
    int          a_ptr = 0;
    logic [7:0]  a_bytes[$];
    int          a_bcyc[$];
    int          a_zero_viol = 0;

    // Instance B: one sample, type 0, ready toggling
    logic        b_start = 1'b0, b_empty = 1'b0, b_ready = 1'b1;
    logic [31:0] b_fdata = '0;
    logic        b_rd, b_valid, b_busy, b_done;
    logic [7:0]  b_data;
    int          b_reads = 0;
    logic [7:0]  b_bytes[$];
    int          b_stalls = 0, b_unstable = 0, b_zero_viol = 0;
    logic        b_hold = 1'b0;
    logic [7:0]  b_hold_data = '0;

    // Instance C: largest legal frame, type 31
    logic        c_start = 1'b0, c_empty = 1'b0, c_ready = 1'b1;
    logic [31:0] c_fdata = '0;
    logic        c_rd, c_valid, c_busy, c_done;
    logic [7:0]  c_data;
    int          c_ptr = 0;
    logic [7:0]  c_bytes[$];
    int          c_bcyc[$];
    int          c_zero_viol = 0;

    uart_streaming_tx u_a (
        .clk(clk), .rst(rst), .start_i(a_start), .fifo_empty_i(a_empty),
        .fifo_data_i(a_fdata), .fifo_rd_o(a_rd), .tx_data_o(a_data),
        .tx_valid_o(a_valid), .tx_ready_i(a_ready), .busy_o(a_busy), .done_o(a_done)
    );

    uart_streaming_tx #(.N_SAMPLES(1), .FRAME_TYPE(5'd0)) u_b (
        .clk(clk), .rst(rst), .start_i(b_start), .fifo_empty_i(b_empty),
        .fifo_data_i(b_fdata), .fifo_rd_o(b_rd), .tx_data_o(b_data),
        .tx_valid_o(b_valid), .tx_ready_i(b_ready), .busy_o(b_busy), .done_o(b_done)
    );

    uart_streaming_tx #(.N_SAMPLES(511), .FRAME_TYPE(5'd31)) u_c (
        .clk(clk), .rst(rst), .start_i(c_start), .fifo_empty_i(c_empty),
        .fifo_data_i(c_fdata), .fifo_rd_o(c_rd), .tx_data_o(c_data),
        .tx_valid_o(c_valid), .tx_ready_i(c_ready), .busy_o(c_busy), .done_o(c_done)
    );

    function automatic logic [31:0] word(input int k);
        return 32'h1234ABCD ^ (32'(k) * 32'h00010003);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (a_rd) begin a_fdata <= word(a_ptr); a_ptr <= a_ptr + 1; end
        if (b_rd) begin b_fdata <= 32'hDEADBEEF; b_reads <= b_reads + 1; end
        if (c_rd) begin c_fdata <= word(c_ptr); c_ptr <= c_ptr + 1; end
    end

    // Byte monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (a_valid && a_ready) begin a_bytes.push_back(a_data); a_bcyc.push_back(cyc); end
        if (!a_valid && a_data !== 8'h00) a_zero_viol++;
        if (c_valid && c_ready) begin c_bytes.push_back(c_data); c_bcyc.push_back(cyc); end
        if (!c_valid && c_data !== 8'h00) c_zero_viol++;
        if (b_valid && b_ready) b_bytes.push_back(b_data);
        if (!b_valid && b_data !== 8'h00) b_zero_viol++;
        if (b_hold && b_data !== b_hold_data) b_unstable++;
        if (b_valid && !b_ready) b_stalls++;
        b_hold      = b_valid && !b_ready;
        b_hold_data = b_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int s0, bi, base, gap, hold_bad;
        logic [7:0] hdr [10];
        logic [7:0] b_exp [11];
        hdr   = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h0C, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD};
        b_exp = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h7E};

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_data",  a_data, 8'h00);
        check("rst_valid", a_valid, 1'b0);
        check("rst_rd",    a_rd, 1'b0);
        check("rst_busy",  a_busy, 1'b0);
        check("rst_done",  a_done, 1'b0);
        check("rst_state", u_a.state_q, ST_IDLE);
        check("rst_cnt",   u_a.cnt_q, 0);
        rst = 1'b0;
        step();

        // Frame 1: default frame with ready=1 and non-empty FIFO
        base = a_ptr; bi = a_bytes.size();
        a_start = 1'b1; s0 = cyc;
        step();
        a_start = 1'b0;
        for (int i = 0; i < 2000 && !a_done; i++) step();
        check("f1_done_seen", a_done, 1'b1);
        check("f1_done_cycle", cyc - s0, 1544);
        step();
        check("f1_byte_count", a_bytes.size() - bi, 1031);
        for (int k = 0; k < 10; k++) check($sformatf("f1_byte%0d", k), a_bytes[bi + k], hdr[k]);
        check("f1_last_payload", a_bytes[bi + 1029], word(base + 255) & 32'hFF);
        check("f1_eof", a_bytes[bi + 1030], 8'h7E);
        check("f1_sof0_cycle", a_bcyc[bi] - s0, 1);
        check("f1_stat1_cycle", a_bcyc[bi + 5] - s0, 6);
        check("f1_eof_cycle", a_bcyc[bi + 1030] - s0, 1543);
        check("f1_reads", a_ptr - base, 256);

        // Frame 2: extra starts in SOF2 and in DONE are dropped
        base = a_ptr; bi = a_bytes.size(); gap = 0;
        a_start = 1'b1; s0 = cyc;
        check("f2_busy_c0", a_busy, 1'b0);
        step();
        a_start = 1'b0;
        for (int i = 0; i < 2000 && !a_done; i++) begin
            if (!a_busy) gap++;
            a_start = (cyc - s0 == 3);
            step();
        end
        check("f2_done_seen", a_done, 1'b1);
        check("f2_busy_gap", gap, 0);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (10) step();
        check("f2_idle_busy", a_busy, 1'b0);
        check("f2_byte_count", a_bytes.size() - bi, 1031);
        check("f2_reads", a_ptr - base, 256);

        // Frame 3: FIFO empty for 20 cycles in FETCH, then reset in REAL1 of sample 3
        base = a_ptr; bi = a_bytes.size(); hold_bad = 0;
        a_empty = 1'b1;
        a_start = 1'b1; s0 = cyc;
        step();
        a_start = 1'b0;
        repeat (6) step();
        check("f3_fetch_state", u_a.state_q, ST_FETCH);
        for (int i = 0; i < 20; i++) begin
            if (a_rd !== 1'b0 || a_valid !== 1'b0) hold_bad++;
            step();
        end
        check("f3_hold_quiet", hold_bad, 0);
        a_empty = 1'b0;
        #1;
        check("f3_rd_pulse", a_rd, 1'b1);
        step();
        check("f3_waitrd_valid", a_valid, 1'b0);
        step();
        check("f3_resume_cycle", cyc - s0, 29);
        check("f3_resume_byte", a_data, word(base) >> 24);
        repeat (19) step();
        check("f3_real1_state", u_a.state_q, ST_REAL1);
        check("f3_real1_byte", a_data, (word(base + 3) >> 16) & 32'hFF);
        rst = 1'b1;
        step();
        check("f3_post_rst_state", u_a.state_q, ST_IDLE);
        check("f3_post_rst_valid", a_valid, 1'b0);
        check("f3_post_rst_data", a_data, 8'h00);
        check("f3_post_rst_busy", a_busy, 1'b0);
        check("f3_post_rst_rd", a_rd, 1'b0);
        check("f3_post_rst_cnt", u_a.cnt_q, 0);
        rst = 1'b0;
        repeat (10) step();
        check("f3_no_more_reads", a_ptr - base, 4);
        check("f3_aborted_bytes", a_bytes.size() - bi, 20);

        // Frame 4: fresh frame after the abort
        base = a_ptr; bi = a_bytes.size();
        a_start = 1'b1; s0 = cyc;
        step();
        a_start = 1'b0;
        for (int i = 0; i < 2000 && !a_done; i++) step();
        check("f4_done_cycle", cyc - s0, 1544);
        step();
        check("f4_byte_count", a_bytes.size() - bi, 1031);
        check("f4_first", a_bytes[bi], 8'hA5);
        check("f4_payload0", a_bytes[bi + 6], word(base) >> 24);
        check("f4_eof", a_bytes[bi + 1030], 8'h7E);
        check("a_zero_when_idle", a_zero_viol, 0);

        // Instance B: N_SAMPLES=1, ready toggling every cycle
        b_ready = 1'b1;
        b_start = 1'b1; s0 = cyc;
        step();
        b_start = 1'b0;
        b_ready = ((cyc - s0) % 2 == 0);
        for (int i = 0; i < 200 && !b_done; i++) begin
            step();
            b_ready = ((cyc - s0) % 2 == 0);
        end
        check("b_done_cycle", cyc - s0, 25);
        step();
        check("b_byte_count", b_bytes.size(), 11);
        for (int k = 0; k < 11; k++) check($sformatf("b_byte%0d", k), b_bytes[k], b_exp[k]);
        check("b_stalls", b_stalls, 11);
        check("b_stable", b_unstable, 0);
        check("b_reads", b_reads, 1);
        check("b_zero_when_idle", b_zero_viol, 0);

        // Instance C: FRAME_TYPE=31, N_SAMPLES=511
        c_start = 1'b1; s0 = cyc;
        step();
        c_start = 1'b0;
        for (int i = 0; i < 4000 && !c_done; i++) step();
        check("c_done_cycle", cyc - s0, 3074);
        step();
        check("c_byte_count", c_bytes.size(), 2051);
        check("c_stat0", c_bytes[4], 8'hFF);
        check("c_stat1", c_bytes[5], 8'hFC);
        check("c_last_payload", c_bytes[2049], word(510) & 32'hFF);
        check("c_eof", c_bytes[2050], 8'h7E);
        check("c_eof_cycle", c_bcyc[2050] - s0, 3073);
        check("c_reads", c_ptr, 511);
        check("c_zero_when_idle", c_zero_viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
